// File: rtl/note_lane_engine.sv
// note_lane_engine
// Drives NUM_LANES falling notes, one per lane, and judges key presses
// against a hit line. Keeps score and combo for the hex display, and
// produces per-pixel note flags and packed note positions for the
// colour mapper.
//
// Ports:
//   Clk, Reset        system clock, synchronous active-high reset
//   frame_clk         VGA vertical sync; its rising edge is a frame tick
//   keycode           current USB keycode
//   spawn_valid/lane  spawn request from the chart sequencer
//   spawn_ready       target lane can take a new note (combinational)
//   DrawX, DrawY      current pixel
//   is_note           pixel lies inside lane i's visible note (registered)
//   note_x_pos/y_pos  packed 10-bit positions, lane 0 in the LSBs
//   hit/miss_pulse    one-cycle judgement strobes per lane
//   lane_state        packed per-lane state: 0 IDLE 1 FALLING 2 HIT 3 MISS
//   score, combo      running score and consecutive-hit count
//
// Spawn handshake: a request transfers on a cycle where spawn_valid and
// spawn_ready are both high. spawn_ready depends only on spawn_lane and
// the lane state, never on spawn_valid, so the sequencer may hold a
// request until it is taken; a request with no ready has no effect.
module note_lane_engine #(
    parameter int                       NUM_LANES    = 5,
    parameter logic [8*NUM_LANES-1:0]   LANE_KEYS    = 40'h0A_09_07_16_04,
    parameter int                       LANE_X0      = 160,
    parameter int                       LANE_PITCH   = 64,
    parameter int                       NOTE_SIZE    = 16,
    parameter int                       FALL_STEP    = 4,
    parameter int                       HIT_Y        = 400,
    parameter int                       HIT_WINDOW   = 12,
    parameter int                       FLASH_FRAMES = 8,
    parameter int                       COMBO_X2     = 10,
    parameter int                       SCORE_W      = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [7:0]                keycode,
    input  logic                      spawn_valid,
    input  logic [2:0]                spawn_lane,
    output logic                      spawn_ready,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [NUM_LANES-1:0]      is_note,
    output logic [10*NUM_LANES-1:0]   note_x_pos,
    output logic [10*NUM_LANES-1:0]   note_y_pos,
    output logic [NUM_LANES-1:0]      hit_pulse,
    output logic [NUM_LANES-1:0]      miss_pulse,
    output logic [2*NUM_LANES-1:0]    lane_state,
    output logic [SCORE_W-1:0]        score,
    output logic [7:0]                combo
);

    localparam int               FW     = $clog2(FLASH_FRAMES + 1);
    localparam logic [10:0]      WIN_LO = 11'(HIT_Y - HIT_WINDOW);
    localparam logic [10:0]      WIN_HI = 11'(HIT_Y + HIT_WINDOW);
    localparam logic [SCORE_W:0] PTS_1  = 1;
    localparam logic [SCORE_W:0] PTS_2  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FALLING = 2'd1,
        ST_HIT     = 2'd2,
        ST_MISS    = 2'd3
    } lane_st_t;

    lane_st_t            st_q    [NUM_LANES];
    lane_st_t            st_d    [NUM_LANES];
    logic [9:0]          y_q     [NUM_LANES];
    logic [9:0]          y_d     [NUM_LANES];
    logic [10:0]         y_next  [NUM_LANES];
    logic [FW-1:0]       flash_q [NUM_LANES];
    logic [FW-1:0]       flash_d [NUM_LANES];

    logic [NUM_LANES-1:0] press;
    logic [NUM_LANES-1:0] in_win;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] miss;
    logic [NUM_LANES-1:0] bad;
    logic [NUM_LANES-1:0] note_d;
    logic [NUM_LANES-1:0] note_q;
    logic [NUM_LANES-1:0] hit_q;
    logic [NUM_LANES-1:0] miss_q;

    logic [SCORE_W-1:0]  score_q;
    logic [SCORE_W-1:0]  score_d;
    logic [SCORE_W:0]    sum;
    logic [7:0]          combo_q;
    logic [7:0]          combo_d;

    logic                fs1, fs2, fs3;
    logic                tick;
    logic [7:0]          keycode_prev;

    // fs1/fs2 synchronise frame_clk; fs3 holds the previous synchronised
    // level so tick fires for exactly one Clk cycle per rising edge.
    assign tick = fs2 & ~fs3;

    always_comb begin
        spawn_ready = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (spawn_lane == 3'(i) && st_q[i] == ST_IDLE) spawn_ready = 1'b1;
        end
    end

    // A press is the first cycle a lane's key appears, so a held key
    // counts once.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            press[i]  = (keycode == LANE_KEYS[i*8 +: 8]) &&
                        (keycode_prev != LANE_KEYS[i*8 +: 8]);
            in_win[i] = ({1'b0, y_q[i]} >= WIN_LO) && ({1'b0, y_q[i]} <= WIN_HI);
            y_next[i] = {1'b0, y_q[i]} + 11'(FALL_STEP);
        end
    end

    // Per-lane next state. A hit is checked before the fall so a press in
    // the window beats a miss caused by the same tick.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            st_d[i]    = st_q[i];
            y_d[i]     = y_q[i];
            flash_d[i] = flash_q[i];
            hit[i]     = 1'b0;
            miss[i]    = 1'b0;
            bad[i]     = 1'b0;
            case (st_q[i])
                ST_IDLE: begin
                    bad[i] = press[i];
                    // Spawn wins over a coincident tick: the note starts at
                    // the top with no fall applied.
                    if (spawn_valid && spawn_lane == 3'(i)) begin
                        st_d[i] = ST_FALLING;
                        y_d[i]  = '0;
                    end
                end
                ST_FALLING: begin
                    if (press[i] && in_win[i]) begin
                        hit[i]     = 1'b1;
                        st_d[i]    = ST_HIT;
                        flash_d[i] = '0;
                    end else begin
                        bad[i] = press[i];
                        if (tick) begin
                            if (y_next[i] > WIN_HI) begin
                                miss[i]    = 1'b1;
                                st_d[i]    = ST_MISS;
                                flash_d[i] = '0;
                            end else begin
                                y_d[i] = y_next[i][9:0];
                            end
                        end
                    end
                end
                ST_HIT, ST_MISS: begin
                    if (tick) begin
                        if (flash_q[i] == FW'(FLASH_FRAMES - 1)) begin
                            st_d[i]    = ST_IDLE;
                            y_d[i]     = '0;
                            flash_d[i] = '0;
                        end else begin
                            flash_d[i] = flash_q[i] + FW'(1);
                        end
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    // Hits are scored in lane order so each sees the combo left by the
    // lanes before it; any miss or bad press still zeroes the final combo.
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        sum     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit[i]) begin
                sum     = {1'b0, score_d} + ((combo_d >= 8'(COMBO_X2)) ? PTS_2 : PTS_1);
                score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                if (combo_d != 8'hFF) combo_d = combo_d + 8'd1;
            end
        end
        if (|miss || |bad) combo_d = '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            note_d[i] = (st_q[i] == ST_FALLING || st_q[i] == ST_HIT) &&
                        ({1'b0, DrawX} >= 11'(LANE_X0 + i*LANE_PITCH)) &&
                        ({1'b0, DrawX} <  11'(LANE_X0 + i*LANE_PITCH + NOTE_SIZE)) &&
                        ({1'b0, DrawY} >= {1'b0, y_q[i]}) &&
                        ({1'b0, DrawY} <  {1'b0, y_q[i]} + 11'(NOTE_SIZE));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                st_q[i]    <= ST_IDLE;
                y_q[i]     <= '0;
                flash_q[i] <= '0;
            end
            note_q       <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            fs1          <= 1'b0;
            fs2          <= 1'b0;
            fs3          <= 1'b0;
            keycode_prev <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                st_q[i]    <= st_d[i];
                y_q[i]     <= y_d[i];
                flash_q[i] <= flash_d[i];
            end
            note_q       <= note_d;
            hit_q        <= hit;
            miss_q       <= miss;
            score_q      <= score_d;
            combo_q      <= combo_d;
            fs1          <= frame_clk;
            fs2          <= fs1;
            fs3          <= fs2;
            keycode_prev <= keycode;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
        assign note_x_pos[g*10 +: 10] = 10'(LANE_X0 + g*LANE_PITCH);
        assign note_y_pos[g*10 +: 10] = y_q[g];
        assign lane_state[g*2 +: 2]   = st_q[g];
    end

    assign is_note    = note_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;

endmodule
